// File: rtl/instr_reg_ctrl.sv
// FIFO controller for instr_register: arbitrated 2-requester write side, in-order valid/ready read side.
// Latency: accept to ir_load_en is 1 cycle; accept to out_valid on an empty FIFO is 2 cycles.
// Backpressure: req_ready drops when committed plus in-flight entries reach DEPTH; a same-cycle pop frees a slot.
module instr_reg_ctrl #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    req_valid,
   output logic [1:0]    req_ready,
   input  logic [3:0]    req0_opcode,
   input  logic [31:0]   req0_operand_a,
   input  logic [31:0]   req0_operand_b,
   input  logic [3:0]    req1_opcode,
   input  logic [31:0]   req1_operand_a,
   input  logic [31:0]   req1_operand_b,
   input  logic          clear,
   output logic          ir_load_en,
   output logic          ir_reset_n,
   output logic [3:0]    ir_opcode,
   output logic [31:0]   ir_operand_a,
   output logic [31:0]   ir_operand_b,
   output logic [AW-1:0] ir_write_ptr,
   output logic [AW-1:0] ir_read_ptr,
   input  logic [67:0]   ir_instr_word,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [67:0]   out_data,
   output logic          div_zero,
   output logic [AW:0]   count
);

   localparam logic       ST_RUN   = 1'b0;
   localparam logic       ST_CLEAR = 1'b1;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_MOD   = 4'd7;

   logic          state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          last_grant;
   logic          ld_vld;
   logic [3:0]    ld_opc;
   logic [31:0]   ld_a;
   logic [31:0]   ld_b;

   logic          run;
   logic          pop;
   logic [AW+1:0] reserved;
   logic          room;
   logic          grant_idx;
   logic          accept;
   logic [3:0]    acc_opc;
   logic [31:0]   acc_a;
   logic [31:0]   acc_b;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign run = (state == ST_RUN) && !reset;
   assign pop = out_valid && out_ready;

   // The pop is credited in the same cycle so a full FIFO can accept while draining.
   assign reserved = {1'b0, cnt} + (AW+2)'(ld_vld) - (AW+2)'(pop);
   assign room     = reserved < (AW+2)'(DEPTH);

   // Both valid: take the requester that was not granted last; otherwise the lone valid one.
   assign grant_idx = (&req_valid) ? ~last_grant : req_valid[1];
   assign accept    = run && !clear && room && (|req_valid);
   assign req_ready = accept ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

   assign acc_opc = grant_idx ? req1_opcode    : req0_opcode;
   assign acc_a   = grant_idx ? req1_operand_a : req0_operand_a;
   assign acc_b   = grant_idx ? req1_operand_b : req0_operand_b;

   assign ir_load_en   = ld_vld && !reset;
   assign ir_reset_n   = run;
   assign ir_opcode    = ld_opc;
   assign ir_operand_a = ld_a;
   assign ir_operand_b = ld_b;
   assign ir_write_ptr = wr_ptr;
   assign ir_read_ptr  = rd_ptr;

   assign out_valid = run && (cnt != '0);
   assign out_data  = ir_instr_word;
   assign count     = cnt;
   assign div_zero  = ir_load_en && ((ld_opc == OP_DIV) || (ld_opc == OP_MOD)) && (ld_b == 32'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         last_grant <= 1'b1;
         ld_vld     <= 1'b0;
         ld_opc     <= '0;
         ld_a       <= '0;
         ld_b       <= '0;
      end else if (state == ST_CLEAR) begin
         state <= ST_RUN;
      end else if (clear) begin
         // An in-flight write is dropped; the CLEAR cycle wipes whatever reached the file.
         state  <= ST_CLEAR;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ld_vld <= 1'b0;
      end else begin
         ld_vld <= accept;
         if (accept) begin
            ld_opc     <= acc_opc;
            ld_a       <= acc_a;
            ld_b       <= acc_b;
            last_grant <= grant_idx;
         end
         if (ld_vld) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)    rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + (AW+1)'(ld_vld) - (AW+1)'(pop);
      end
   end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Bench for instr_reg_ctrl: directed scenarios plus a randomized run against a queue-based FIFO model.
module tb_instr_reg_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req0_opcode, req1_opcode;
   logic [31:0] req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
   logic        clear;
   logic        ir_load_en, ir_reset_n;
   logic [3:0]  ir_opcode;
   logic [31:0] ir_operand_a, ir_operand_b;
   logic [4:0]  ir_write_ptr, ir_read_ptr;
   logic [67:0] ir_instr_word;
   logic        out_valid, out_ready;
   logic [67:0] out_data;
   logic        div_zero;
   logic [5:0]  count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_reg_ctrl #(.DEPTH(32), .AW(5)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_opcode(req0_opcode), .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
      .req1_opcode(req1_opcode), .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
      .clear(clear),
      .ir_load_en(ir_load_en), .ir_reset_n(ir_reset_n),
      .ir_opcode(ir_opcode), .ir_operand_a(ir_operand_a), .ir_operand_b(ir_operand_b),
      .ir_write_ptr(ir_write_ptr), .ir_read_ptr(ir_read_ptr),
      .ir_instr_word(ir_instr_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .div_zero(div_zero), .count(count)
   );

   // Stand-in for instr_register: 32-entry file with active-low reset.
   logic [67:0] iw [32];
   always @(posedge clk) begin
      if (!ir_reset_n) begin
         for (int i = 0; i < 32; i++) iw[i] <= '0;
      end else if (ir_load_en) begin
         iw[ir_write_ptr] <= {ir_opcode, ir_operand_a, ir_operand_b};
      end
   end
   assign ir_instr_word = iw[ir_read_ptr];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; clear = 1'b0; out_ready = 1'b0; req_valid = 2'b00;
      req0_opcode = 4'd3; req0_operand_a = '0; req0_operand_b = '0;
      req1_opcode = 4'd3; req1_operand_a = '0; req1_operand_b = '0;
      tick; tick;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; clear = 1'b0; out_ready = 1'b1; req_valid = 2'b11;
      req0_opcode = 4'd3; req0_operand_a = 1; req0_operand_b = 2;
      req1_opcode = 4'd3; req1_operand_a = 3; req1_operand_b = 4;
      tick; tick;
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      checks++; if (ir_reset_n !== 1'b0) begin errors++; $display("FAIL reset_ir_reset_n got=%b exp=0", ir_reset_n); end
      checks++; if (ir_load_en !== 1'b0) begin errors++; $display("FAIL reset_load_en got=%b exp=0", ir_load_en); end
      checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_outs got=%b%b exp=00", out_valid, div_zero); end
      checks++; if (ir_write_ptr !== 5'd0 || ir_read_ptr !== 5'd0) begin errors++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", ir_write_ptr, ir_read_ptr); end
      tick;
      reset = 1'b0; req_valid = 2'b00;
      @(negedge clk);
      checks++; if (ir_reset_n !== 1'b1) begin errors++; $display("FAIL reset_release got=%b exp=1", ir_reset_n); end
      tick;
   endtask

   task automatic test_single;
      do_reset;
      out_ready = 1'b1; req_valid = 2'b01;
      req0_opcode = 4'd3; req0_operand_a = 7; req0_operand_b = 3;
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t1_ready got=%b exp=01", req_ready); end
      tick; req_valid = 2'b00;
      @(negedge clk);
      checks++; if (ir_load_en !== 1'b1 || ir_write_ptr !== 5'd0) begin errors++; $display("FAIL t1_load got=%b ptr=%0d exp=1 ptr=0", ir_load_en, ir_write_ptr); end
      checks++; if ({ir_opcode, ir_operand_a, ir_operand_b} !== {4'd3, 32'd7, 32'd3}) begin errors++; $display("FAIL t1_ir_data got=%h", {ir_opcode, ir_operand_a, ir_operand_b}); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got=%b exp=0", out_valid); end
      tick;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || count !== 6'd1) begin errors++; $display("FAIL t1_valid got=%b cnt=%0d exp=1 cnt=1", out_valid, count); end
      checks++; if (out_data !== {4'd3, 32'd7, 32'd3}) begin errors++; $display("FAIL t1_out_data got=%h exp=%h", out_data, {4'd3, 32'd7, 32'd3}); end
      tick;
      @(negedge clk);
      checks++; if (count !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_drain got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid); end
   endtask

   task automatic test_arbitration;
      int n0 = 0, n1 = 0;
      logic [1:0] exp;
      do_reset;
      req0_operand_a = 100; req1_operand_a = 200; req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         exp = (k % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++; if (req_ready !== exp) begin errors++; $display("FAIL t2_grant%0d got=%b exp=%b", k, req_ready, exp); end
         if (k > 0) begin
            checks++; if (ir_load_en !== 1'b1 || ir_write_ptr !== 5'(k - 1)) begin errors++; $display("FAIL t2_wptr%0d got=%b/%0d exp=1/%0d", k, ir_load_en, ir_write_ptr, k - 1); end
         end
         tick;
         if (exp == 2'b01) begin n0++; req0_operand_a = 100 + n0; end
         else begin n1++; req1_operand_a = 200 + n1; end
      end
      req_valid = 2'b00;
      tick; tick;
      @(negedge clk);
      checks++; if (count !== 6'd6) begin errors++; $display("FAIL t2_count got=%0d exp=6", count); end
      tick;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data[63:32] !== 32'((k % 2 == 0) ? 100 + k / 2 : 200 + k / 2)) begin
            errors++; $display("FAIL t2_order%0d got v=%b a=%0d exp a=%0d", k, out_valid, out_data[63:32], (k % 2 == 0) ? 100 + k / 2 : 200 + k / 2);
         end
         tick;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_full;
      do_reset;
      req_valid = 2'b01; req0_operand_a = 0; req0_operand_b = 1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t3_fill%0d got=%b exp=01", k, req_ready); end
         tick;
         req0_operand_a = k + 1;
      end
      @(negedge clk);
      checks++; if (req_ready !== 2'b00 || count !== 6'd31) begin errors++; $display("FAIL t3_inflight got=%b cnt=%0d exp=00 cnt=31", req_ready, count); end
      tick;
      @(negedge clk);
      checks++; if (req_ready !== 2'b00 || count !== 6'd32) begin errors++; $display("FAIL t3_full got=%b cnt=%0d exp=00 cnt=32", req_ready, count); end
      tick;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t3_pop_ready got=%b exp=01", req_ready); end
      checks++; if (out_data[63:32] !== 32'd0) begin errors++; $display("FAIL t3_head got=%0d exp=0", out_data[63:32]); end
      tick;
      out_ready = 1'b0; req_valid = 2'b00;
      @(negedge clk);
      checks++; if (ir_load_en !== 1'b1 || ir_write_ptr !== 5'd0 || count !== 6'd31) begin errors++; $display("FAIL t3_wrap got=%b ptr=%0d cnt=%0d exp=1 ptr=0 cnt=31", ir_load_en, ir_write_ptr, count); end
      tick;
      @(negedge clk);
      checks++; if (count !== 6'd32 || ir_read_ptr !== 5'd1) begin errors++; $display("FAIL t3_refill got cnt=%0d rp=%0d exp cnt=32 rp=1", count, ir_read_ptr); end
   endtask

   task automatic test_div_zero;
      logic [3:0] opc [3] = '{4'd6, 4'd7, 4'd3};
      logic [31:0] b [3] = '{32'd0, 32'd5, 32'd0};
      logic dz [3] = '{1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 3; k++) begin
         do_reset;
         req_valid = 2'b01; req0_opcode = opc[k]; req0_operand_a = 9; req0_operand_b = b[k];
         @(negedge clk);
         tick; req_valid = 2'b00;
         @(negedge clk);
         checks++; if (div_zero !== dz[k] || ir_load_en !== 1'b1) begin errors++; $display("FAIL t4_dz%0d got=%b load=%b exp=%b load=1", k, div_zero, ir_load_en, dz[k]); end
         tick;
         @(negedge clk);
         checks++; if (div_zero !== 1'b0 || count !== 6'd1) begin errors++; $display("FAIL t4_after%0d got dz=%b cnt=%0d exp dz=0 cnt=1", k, div_zero, count); end
         checks++; if (out_data !== {opc[k], 32'd9, b[k]}) begin errors++; $display("FAIL t4_data%0d got=%h", k, out_data); end
      end
   endtask

   task automatic test_clear;
      do_reset;
      req_valid = 2'b01;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); tick; req0_operand_a = k + 1;
      end
      req_valid = 2'b00;
      tick; tick;
      @(negedge clk);
      checks++; if (count !== 6'd5) begin errors++; $display("FAIL t5_preload got=%0d exp=5", count); end
      tick;
      req_valid = 2'b01; clear = 1'b1; req0_operand_a = 77;
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t5_clear_wins got=%b exp=00", req_ready); end
      tick; clear = 1'b0;
      @(negedge clk);
      checks++; if (ir_reset_n !== 1'b0 || req_ready !== 2'b00 || out_valid !== 1'b0) begin errors++; $display("FAIL t5_clear_cycle got rn=%b rdy=%b v=%b exp 0/00/0", ir_reset_n, req_ready, out_valid); end
      checks++; if (count !== 6'd0 || ir_write_ptr !== 5'd0 || ir_read_ptr !== 5'd0) begin errors++; $display("FAIL t5_zeroed got cnt=%0d wp=%0d rp=%0d exp 0", count, ir_write_ptr, ir_read_ptr); end
      tick;
      @(negedge clk);
      checks++; if (ir_reset_n !== 1'b1 || req_ready !== 2'b01) begin errors++; $display("FAIL t5_resume got rn=%b rdy=%b exp 1/01", ir_reset_n, req_ready); end
      tick; req_valid = 2'b00;
      @(negedge clk);
      checks++; if (ir_load_en !== 1'b1 || ir_write_ptr !== 5'd0) begin errors++; $display("FAIL t5_first_write got=%b ptr=%0d exp=1 ptr=0", ir_load_en, ir_write_ptr); end
      tick;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data[63:32] !== 32'd77 || count !== 6'd1) begin errors++; $display("FAIL t5_readback got v=%b a=%0d cnt=%0d exp 1/77/1", out_valid, out_data[63:32], count); end
   endtask

   task automatic test_reset_midop;
      do_reset;
      req_valid = 2'b01; req0_operand_a = 55;
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t6_ready got=%b exp=01", req_ready); end
      tick;
      req_valid = 2'b00; reset = 1'b1;
      @(negedge clk);
      checks++; if (ir_load_en !== 1'b0 || ir_reset_n !== 1'b0) begin errors++; $display("FAIL t6_during got load=%b rn=%b exp 0/0", ir_load_en, ir_reset_n); end
      tick;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (ir_load_en !== 1'b0 || count !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL t6_after got load=%b cnt=%0d v=%b exp 0/0/0", ir_load_en, count, out_valid); end
      tick;
      @(negedge clk);
      checks++; if (ir_load_en !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL t6_no_pulse got load=%b cnt=%0d exp 0/0", ir_load_en, count); end
   endtask

   task automatic test_random;
      logic [67:0] q [$];
      logic [67:0] rd [2];
      logic [1:0]  rv = 2'b00;
      logic        infl_v = 1'b0;
      logic [67:0] infl_d = '0;
      logic        clearing = 1'b0;
      int          lastg = 1;
      int          wcnt = 0, rcnt = 0;
      int          sel;
      logic        ov, pop, room, exp_dz;
      logic [1:0]  exp_rdy;
      do_reset;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!rv[i] && $urandom_range(0, 2) != 0) begin
               rv[i] = 1'b1;
               rd[i] = {4'($urandom_range(0, 7)), 32'($urandom), ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom)};
            end
         end
         req_valid = rv;
         {req0_opcode, req0_operand_a, req0_operand_b} = rd[0];
         {req1_opcode, req1_operand_a, req1_operand_b} = rd[1];
         clear = ($urandom_range(0, 79) == 0);
         out_ready = (cyc % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);

         ov   = !clearing && (q.size() != 0);
         pop  = ov && out_ready;
         room = (q.size() + int'(infl_v) - int'(pop)) < 32;
         sel  = (rv == 2'b11) ? 1 - lastg : (rv[1] ? 1 : 0);
         exp_rdy = (!clearing && !clear && room && rv != 2'b00) ? 2'(1 << sel) : 2'b00;
         exp_dz  = infl_v && (infl_d[67:64] == 4'd6 || infl_d[67:64] == 4'd7) && infl_d[31:0] == 32'd0;

         @(negedge clk);
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
         checks++; if (out_valid !== ov) begin errors++; $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, out_valid, ov); end
         checks++; if (count !== 6'(q.size())) begin errors++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", cyc, count, q.size()); end
         checks++; if (ir_load_en !== infl_v || div_zero !== exp_dz) begin errors++; $display("FAIL rnd_load c%0d got=%b dz=%b exp=%b dz=%b", cyc, ir_load_en, div_zero, infl_v, exp_dz); end
         checks++; if (ir_reset_n !== !clearing) begin errors++; $display("FAIL rnd_reset_n c%0d got=%b exp=%b", cyc, ir_reset_n, !clearing); end
         checks++; if (ir_read_ptr !== 5'(rcnt % 32)) begin errors++; $display("FAIL rnd_rptr c%0d got=%0d exp=%0d", cyc, ir_read_ptr, rcnt % 32); end
         if (infl_v) begin
            checks++; if (ir_write_ptr !== 5'(wcnt % 32)) begin errors++; $display("FAIL rnd_wptr c%0d got=%0d exp=%0d", cyc, ir_write_ptr, wcnt % 32); end
         end
         if (ov) begin
            checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, out_data, q[0]); end
         end
         tick;

         if (clearing) begin
            clearing = 1'b0;
         end else if (clear) begin
            clearing = 1'b1; q.delete(); infl_v = 1'b0; wcnt = 0; rcnt = 0;
         end else begin
            if (pop) begin void'(q.pop_front()); rcnt++; end
            if (infl_v) begin q.push_back(infl_d); wcnt++; end
            infl_v = (exp_rdy != 2'b00);
            if (infl_v) begin infl_d = rd[sel]; lastg = sel; rv[sel] = 1'b0; end
         end
      end
      clear = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single;
      test_arbitration;
      test_full;
      test_div_zero;
      test_clear;
      test_reset_midop;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
